// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: state encoding,
// size helpers and the well-known I/O window base address.
package mem_ctrl_pkg;

   localparam int ST_W = 2;

   localparam logic [ST_W-1:0] ST_IDLE    = 2'd0;
   localparam logic [ST_W-1:0] ST_RD      = 2'd1;
   localparam logic [ST_W-1:0] ST_RD_TAIL = 2'd2;
   localparam logic [ST_W-1:0] ST_WR      = 2'd3;

   localparam logic [31:0] IO_BASE = 32'h0003_0000;

   localparam int MAX_DATA_W = 64;

   // Bytes carried by one request word.
   function automatic int calcNb(input int dataW);
      return dataW / 8;
   endfunction

   // Width of a length field able to hold 0..NB (and beyond, up to 2*NB-1).
   function automatic int calcLenW(input int dataW);
      return $clog2(dataW / 8) + 1;
   endfunction

endpackage

// File: rtl/mem_arb.sv
// Request arbiter: combinational grant over the valid ports, either fixed
// priority (lowest index wins) or round-robin starting after the last winner.
module mem_arb
   import mem_ctrl_pkg::*;
#(
   parameter int NPORT  = 2,
   parameter int ARB_RR = 0
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic [NPORT-1:0]         req_i,
   input  logic                     advance_i,
   output logic                     gntValid_o,
   output logic [$clog2(NPORT)-1:0] gntIdx_o
);

   localparam int IDX_W = $clog2(NPORT);

   logic [IDX_W-1:0] ptr_q;
   int               cand;

   // Pick a winner; later loop iterations override earlier ones, so the loops
   // run from the least to the most preferred candidate.
   always_comb begin
      gntValid_o = 1'b0;
      gntIdx_o   = '0;
      cand       = 0;
      if (ARB_RR == 0) begin
         for (int i = NPORT - 1; i >= 0; i--) begin
            if (req_i[i]) begin
               gntValid_o = 1'b1;
               gntIdx_o   = IDX_W'(i);
            end
         end
      end else begin
         for (int off = NPORT; off >= 1; off--) begin
            cand = int'(ptr_q) + off;
            if (cand >= NPORT) begin
               cand = cand - NPORT;
            end
            if (req_i[cand]) begin
               gntValid_o = 1'b1;
               gntIdx_o   = IDX_W'(cand);
            end
         end
      end
   end

   // Remember the last port actually accepted; reset points at the top port
   // so the first search starts at port 0.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         ptr_q <= IDX_W'(NPORT - 1);
      end else if (advance_i && gntValid_o) begin
         ptr_q <= gntIdx_o;
      end
   end

endmodule

// File: rtl/mem_ctrl.sv
// Multi-port byte-serial memory controller. Each accepted request moves up
// to NB bytes one at a time over an 8-bit memory port whose read data comes
// back one cycle after the address.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter  int NPORT  = 2,
   parameter  int DATA_W = 32,
   parameter  int ARB_RR = 0,
   localparam int NB     = calcNb(DATA_W),
   localparam int LEN_W  = calcLenW(DATA_W)
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic                      rdy_in,
   input  logic [NPORT-1:0]          req_valid,
   input  logic [NPORT-1:0]          req_we,
   input  logic [NPORT*32-1:0]       req_addr,
   input  logic [NPORT*LEN_W-1:0]    req_len,
   input  logic [NPORT*DATA_W-1:0]   req_wdata,
   output logic [NPORT-1:0]          done,
   output logic [DATA_W-1:0]         rdata,
   output logic                      busy,
   input  logic [7:0]                mem_din,
   output logic [7:0]                mem_dout,
   output logic [31:0]               mem_a,
   output logic                      mem_wr
);

   localparam int IDX_W = $clog2(NPORT);

   logic [ST_W-1:0]   state_q,   state_d;
   logic [IDX_W-1:0]  port_q,    port_d;
   logic [31:0]       addr_q,    addr_d;
   logic [LEN_W-1:0]  len_q,     len_d;
   logic [DATA_W-1:0] wdata_q,   wdata_d;
   logic [LEN_W-1:0]  byteCnt_q, byteCnt_d;
   logic [DATA_W-1:0] readBuf_q, readBuf_d;
   logic [DATA_W-1:0] rdata_q,   rdata_d;
   logic [NPORT-1:0]  done_q,    done_d;

   logic              gntValid;
   logic [IDX_W-1:0]  gntIdx;
   logic              accept;
   logic [LEN_W-1:0]  gntLen;
   logic [LEN_W-1:0]  gntLenEff;
   logic [LEN_W-1:0]  lastIdx;

   mem_arb #(
      .NPORT  (NPORT),
      .ARB_RR (ARB_RR)
   ) uArb (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .req_i      (req_valid),
      .advance_i  (accept),
      .gntValid_o (gntValid),
      .gntIdx_o   (gntIdx)
   );

   // Winner's length, with 0 and oversize lengths meaning a full word.
   always_comb begin
      gntLen    = req_len[int'(gntIdx) * LEN_W +: LEN_W];
      gntLenEff = gntLen;
      if ((gntLen == '0) || (gntLen > LEN_W'(NB))) begin
         gntLenEff = LEN_W'(NB);
      end
      lastIdx = len_q - LEN_W'(1);
   end

   // Next-state logic; a low rdy_in leaves every register at its current value.
   always_comb begin
      state_d   = state_q;
      port_d    = port_q;
      addr_d    = addr_q;
      len_d     = len_q;
      wdata_d   = wdata_q;
      byteCnt_d = byteCnt_q;
      readBuf_d = readBuf_q;
      rdata_d   = rdata_q;
      done_d    = done_q;
      accept    = 1'b0;

      if (rdy_in) begin
         done_d = '0;
         case (state_q)
            ST_IDLE: begin
               if (gntValid) begin
                  accept    = 1'b1;
                  port_d    = gntIdx;
                  addr_d    = req_addr[int'(gntIdx) * 32 +: 32];
                  len_d     = gntLenEff;
                  wdata_d   = req_wdata[int'(gntIdx) * DATA_W +: DATA_W];
                  byteCnt_d = '0;
                  readBuf_d = '0;
                  state_d   = req_we[gntIdx] ? ST_WR : ST_RD;
               end
            end
            ST_RD: begin
               if (!req_valid[port_q]) begin
                  state_d = ST_IDLE;
               end else begin
                  if (byteCnt_q != '0) begin
                     readBuf_d[8 * int'(byteCnt_q - LEN_W'(1)) +: 8] = mem_din;
                  end
                  if (byteCnt_q == lastIdx) begin
                     state_d = ST_RD_TAIL;
                  end else begin
                     byteCnt_d = byteCnt_q + LEN_W'(1);
                  end
               end
            end
            ST_RD_TAIL: begin
               state_d = ST_IDLE;
               if (req_valid[port_q]) begin
                  readBuf_d[8 * int'(lastIdx) +: 8] = mem_din;
                  rdata_d          = readBuf_d;
                  done_d[port_q]   = 1'b1;
               end
            end
            default: begin
               if (byteCnt_q == lastIdx) begin
                  done_d[port_q] = 1'b1;
                  state_d        = ST_IDLE;
               end else begin
                  byteCnt_d = byteCnt_q + LEN_W'(1);
               end
            end
         endcase
      end
   end

   // State registers; reset wins over rdy_in and silently drops any transfer.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q   <= ST_IDLE;
         port_q    <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         wdata_q   <= '0;
         byteCnt_q <= '0;
         readBuf_q <= '0;
         rdata_q   <= '0;
         done_q    <= '0;
      end else begin
         state_q   <= state_d;
         port_q    <= port_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         wdata_q   <= wdata_d;
         byteCnt_q <= byteCnt_d;
         readBuf_q <= readBuf_d;
         rdata_q   <= rdata_d;
         done_q    <= done_d;
      end
   end

   // Memory-side outputs derive from held state, so a stall keeps the address
   // steady while the write strobe is gated off until rdy_in returns.
   always_comb begin
      mem_a    = '0;
      mem_dout = '0;
      mem_wr   = 1'b0;
      if (state_q != ST_IDLE) begin
         mem_a = addr_q + 32'(byteCnt_q);
      end
      if (state_q == ST_WR) begin
         mem_dout = wdata_q[8 * int'(byteCnt_q) +: 8];
         mem_wr   = rdy_in;
      end
   end

   // Requester-side outputs.
   always_comb begin
      done  = done_q;
      rdata = rdata_q;
      busy  = (state_q != ST_IDLE);
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a fixed-priority and a round-robin instance
// share the same stimulus, each with its own one-cycle-latency byte memory.
module tb_mem_ctrl;
   import mem_ctrl_pkg::*;

   localparam int NPORT  = 2;
   localparam int DATA_W = 32;
   localparam int LEN_W  = calcLenW(DATA_W);

   logic                    clock;
   logic                    reset;
   logic                    ready;
   logic [NPORT-1:0]        reqValid;
   logic [NPORT-1:0]        reqWe;
   logic [NPORT*32-1:0]     reqAddr;
   logic [NPORT*LEN_W-1:0]  reqLen;
   logic [NPORT*DATA_W-1:0] reqWdata;

   logic [NPORT-1:0]  fpDone,    rrDone;
   logic [DATA_W-1:0] fpRdata,   rrRdata;
   logic              fpBusy,    rrBusy;
   logic [7:0]        fpMemDin,  rrMemDin;
   logic [7:0]        fpMemDout, rrMemDout;
   logic [31:0]       fpMemA,    rrMemA;
   logic              fpMemWr,   rrMemWr;

   int vectorCount = 0;
   int miscompareCount = 0;

   logic [31:0] wrAddrLog[$];
   logic [7:0]  wrDataLog[$];

   mem_ctrl #(.NPORT(NPORT), .DATA_W(DATA_W), .ARB_RR(0)) dutFp (
      .clk_in    (clock),
      .rst_in    (reset),
      .rdy_in    (ready),
      .req_valid (reqValid),
      .req_we    (reqWe),
      .req_addr  (reqAddr),
      .req_len   (reqLen),
      .req_wdata (reqWdata),
      .done      (fpDone),
      .rdata     (fpRdata),
      .busy      (fpBusy),
      .mem_din   (fpMemDin),
      .mem_dout  (fpMemDout),
      .mem_a     (fpMemA),
      .mem_wr    (fpMemWr)
   );

   mem_ctrl #(.NPORT(NPORT), .DATA_W(DATA_W), .ARB_RR(1)) dutRr (
      .clk_in    (clock),
      .rst_in    (reset),
      .rdy_in    (ready),
      .req_valid (reqValid),
      .req_we    (reqWe),
      .req_addr  (reqAddr),
      .req_len   (reqLen),
      .req_wdata (reqWdata),
      .done      (rrDone),
      .rdata     (rrRdata),
      .busy      (rrBusy),
      .mem_din   (rrMemDin),
      .mem_dout  (rrMemDout),
      .mem_a     (rrMemA),
      .mem_wr    (rrMemWr)
   );

   // Free-running clock, 10 time units per cycle.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Fixed memory image used by the reads.
   function automatic logic [7:0] memByte(input logic [31:0] a);
      case (a)
         32'h0000_0100: return 8'h11;
         32'h0000_0101: return 8'h22;
         32'h0000_0102: return 8'h33;
         32'h0000_0103: return 8'h44;
         32'hFFFF_FFFF: return 8'hA5;
         32'h0000_0000: return 8'h5C;
         default:       return a[7:0] ^ 8'h3C;
      endcase
   endfunction

   // Synchronous memories: data for an address appears in the following cycle.
   always @(posedge clock) begin
      fpMemDin <= memByte(fpMemA);
      rrMemDin <= memByte(rrMemA);
   end

   // Log every byte the fixed-priority instance writes, once per cycle.
   always @(negedge clock) begin
      if (fpMemWr === 1'b1) begin
         wrAddrLog.push_back(fpMemA);
         wrDataLog.push_back(fpMemDout);
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      vectorCount++;
      if (actual !== expected) begin
         miscompareCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int port, input logic we, input logic [31:0] addr,
                                input logic [LEN_W-1:0] len, input logic [31:0] wdata);
      reqValid[port]                  = 1'b1;
      reqWe[port]                     = we;
      reqAddr[port*32 +: 32]          = addr;
      reqLen[port*LEN_W +: LEN_W]     = len;
      reqWdata[port*DATA_W +: DATA_W] = wdata;
   endtask

   task automatic dropValid(input int port);
      reqValid[port] = 1'b0;
   endtask

   task automatic nextCycle();
      @(posedge clock);
      #1;
   endtask

   task automatic midCycle();
      @(negedge clock);
   endtask

   initial begin
      logic [NPORT-1:0] expFp;
      logic [NPORT-1:0] expRr;
      logic [LEN_W-1:0] lenCase [2];

      reset    = 1'b1;
      ready    = 1'b1;
      reqValid = '0;
      reqWe    = '0;
      reqAddr  = '0;
      reqLen   = '0;
      reqWdata = '0;

      $display("[TB] reset");
      nextCycle();
      nextCycle();
      midCycle();
      checkOutput("rstDone",  fpDone,    0);
      checkOutput("rstRdata", fpRdata,   0);
      checkOutput("rstBusy",  fpBusy,    0);
      checkOutput("rstMemWr", fpMemWr,   0);
      checkOutput("rstMemA",  fpMemA,    0);
      checkOutput("rstDout",  fpMemDout, 0);
      checkOutput("rstBusyRr", rrBusy,   0);
      nextCycle();
      reset = 1'b0;

      $display("[TB] port0 read len 4 at 0x100");
      nextCycle();
      applyStimulus(0, 1'b0, 32'h100, 3'd4, 32'h0);
      midCycle();
      checkOutput("rdC0Busy", fpBusy, 0);
      for (int c = 1; c <= 5; c++) begin
         nextCycle();
         midCycle();
         if (c <= 4) checkOutput("rdAddr", fpMemA, 32'h100 + c - 1);
         checkOutput("rdNoDone", fpDone, 0);
         checkOutput("rdBusy", fpBusy, 1);
      end
      nextCycle();
      dropValid(0);
      midCycle();
      checkOutput("rdDone",  fpDone,  2'b01);
      checkOutput("rdData",  fpRdata, 32'h4433_2211);
      checkOutput("rdIdle",  fpBusy,  0);
      nextCycle();
      midCycle();
      checkOutput("rdDonePulse", fpDone,  0);
      checkOutput("rdHold",      fpRdata, 32'h4433_2211);

      $display("[TB] port1 write len 2 at I/O base");
      nextCycle();
      applyStimulus(1, 1'b1, IO_BASE, 3'd2, 32'h0000_BEEF);
      midCycle();
      nextCycle();
      dropValid(1);
      midCycle();
      checkOutput("wrC1Wr",   fpMemWr,   1);
      checkOutput("wrC1Addr", fpMemA,    32'h0003_0000);
      checkOutput("wrC1Byte", fpMemDout, 8'hEF);
      nextCycle();
      midCycle();
      checkOutput("wrC2Wr",   fpMemWr,   1);
      checkOutput("wrC2Addr", fpMemA,    32'h0003_0001);
      checkOutput("wrC2Byte", fpMemDout, 8'hBE);
      checkOutput("wrC2NoDone", fpDone,  0);
      nextCycle();
      midCycle();
      checkOutput("wrDone",   fpDone,    2'b10);
      checkOutput("wrIdleWr", fpMemWr,   0);
      checkOutput("wrIdleA",  fpMemA,    0);
      checkOutput("wrIdleDo", fpMemDout, 0);
      checkOutput("wrKeepRd", fpRdata,   32'h4433_2211);

      $display("[TB] 4-byte write with a 3-cycle stall on byte 1");
      wrAddrLog.delete();
      wrDataLog.delete();
      nextCycle();
      applyStimulus(0, 1'b1, 32'h200, 3'd4, 32'hDDCC_BBAA);
      midCycle();
      for (int c = 1; c <= 8; c++) begin
         nextCycle();
         if (c == 1) dropValid(0);
         ready = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
         midCycle();
         checkOutput("stDone", fpDone, (c == 8) ? 2'b01 : 2'b00);
         if (c >= 2 && c <= 4) begin
            checkOutput("stHoldWr", fpMemWr, 0);
            checkOutput("stHoldA",  fpMemA,  32'h201);
         end
      end
      checkOutput("stWrCount", wrAddrLog.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < wrAddrLog.size()) begin
            checkOutput("stWrAddr", wrAddrLog[i], 32'h200 + i);
            checkOutput("stWrByte", wrDataLog[i], 8'hAA + 8'(i * 8'h11));
         end
      end

      $display("[TB] read abort in cycle 2");
      nextCycle();
      applyStimulus(0, 1'b0, 32'h300, 3'd4, 32'h0);
      midCycle();
      nextCycle();
      midCycle();
      nextCycle();
      dropValid(0);
      midCycle();
      for (int c = 3; c <= 7; c++) begin
         nextCycle();
         midCycle();
         if (c == 3) checkOutput("abIdle", fpBusy, 0);
         checkOutput("abNoDone", fpDone, 0);
      end
      checkOutput("abRdata", fpRdata, 32'h4433_2211);

      $display("[TB] read len 2 wrapping at 0xFFFFFFFF");
      nextCycle();
      applyStimulus(0, 1'b0, 32'hFFFF_FFFF, 3'd2, 32'h0);
      midCycle();
      nextCycle();
      midCycle();
      checkOutput("wrapA0", fpMemA, 32'hFFFF_FFFF);
      nextCycle();
      midCycle();
      checkOutput("wrapA1", fpMemA, 32'h0000_0000);
      nextCycle();
      midCycle();
      checkOutput("wrapTail", fpDone, 0);
      nextCycle();
      dropValid(0);
      midCycle();
      checkOutput("wrapDone",  fpDone,  2'b01);
      checkOutput("wrapRdata", fpRdata, 32'h0000_5CA5);

      $display("[TB] len 0 and len > NB mean a full word");
      lenCase[0] = 3'd0;
      lenCase[1] = 3'd6;
      for (int t = 0; t < 2; t++) begin
         nextCycle();
         applyStimulus(0, 1'b0, 32'h100, lenCase[t], 32'h0);
         midCycle();
         for (int c = 1; c <= 5; c++) begin
            nextCycle();
            midCycle();
            checkOutput("lenNoDone", fpDone, 0);
         end
         nextCycle();
         dropValid(0);
         midCycle();
         checkOutput("lenDone",  fpDone,  2'b01);
         checkOutput("lenRdata", fpRdata, 32'h4433_2211);
      end

      $display("[TB] reset during a read, with rdy low");
      nextCycle();
      applyStimulus(0, 1'b0, 32'h100, 3'd4, 32'h0);
      midCycle();
      nextCycle();
      midCycle();
      nextCycle();
      reset = 1'b1;
      ready = 1'b0;
      midCycle();
      checkOutput("rsBusyPre", fpBusy, 1);
      nextCycle();
      reset = 1'b0;
      ready = 1'b1;
      dropValid(0);
      midCycle();
      checkOutput("rsBusy",  fpBusy,  0);
      checkOutput("rsRdata", fpRdata, 0);
      for (int c = 4; c <= 7; c++) begin
         nextCycle();
         midCycle();
         checkOutput("rsNoDone", fpDone, 0);
      end

      $display("[TB] both ports valid, len 1 reads");
      nextCycle();
      applyStimulus(0, 1'b0, 32'h100, 3'd1, 32'h0);
      applyStimulus(1, 1'b0, 32'h101, 3'd1, 32'h0);
      midCycle();
      for (int c = 1; c <= 12; c++) begin
         nextCycle();
         if (c == 12) reqValid = '0;
         midCycle();
         expFp = (c % 3 == 0) ? 2'b01 : 2'b00;
         expRr = 2'b00;
         if (c % 3 == 0) expRr = ((c / 3) % 2 == 1) ? 2'b01 : 2'b10;
         checkOutput("arbFp", fpDone, expFp);
         checkOutput("arbRr", rrDone, expRr);
         if (c % 3 == 0) begin
            checkOutput("arbFpData", fpRdata, 32'h11);
            checkOutput("arbRrData", rrRdata, ((c / 3) % 2 == 1) ? 32'h11 : 32'h22);
         end
      end

      nextCycle();
      nextCycle();
      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter NPORT, default 2, number of requester ports (2..4).
REQ-002 SHALL have parameter DATA_W, default 32, request data width (multiple of 8, max 64); NB = DATA_W/8 bytes.
REQ-003 SHALL have parameter ARB_RR, default 0, arbitration mode (0 = fixed priority, lowest index wins; 1 = round-robin).
REQ-004 SHALL have the port `clk_in  in  1`: single clock, all state on rising edge.
REQ-005 SHALL have the port `rst_in  in  1`: reset, synchronous, active-high.
REQ-006 SHALL have the port `rdy_in  in  1`: pause; low freezes all state.
REQ-007 SHALL have the port `req_valid  in  NPORT`: per-port request.
REQ-008 SHALL have the port `req_we  in  NPORT`: per-port write (1) / read (0).
REQ-009 SHALL have the port `req_addr  in  NPORT*32`: per-port byte start address.
REQ-010 SHALL have the port `req_len  in  NPORT*LEN_W`: per-port byte count; LEN_W = clog2(NB)+1.
REQ-011 SHALL have the port `req_wdata  in  NPORT*DATA_W`: per-port write data, little-endian.
REQ-012 SHALL have the port `done  out  NPORT`: one-cycle completion pulse per port.
REQ-013 SHALL have the port `rdata  out  DATA_W`: read result, valid when any done bit is high for a read.
REQ-014 SHALL have the port `busy  out  1`: a transfer is in progress.
REQ-015 SHALL have the port `mem_din  in  8`: byte from memory.
REQ-016 SHALL have the port `mem_dout  out  8`: byte to memory.
REQ-017 SHALL have the port `mem_a  out  32`: byte address.
REQ-018 SHALL have the port `mem_wr  out  1`: 1 = write.

Function
REQ-019 SHALL use FSM states IDLE, RD, RD_TAIL and WR.
REQ-020 SHALL, in IDLE with any req_valid, latch the winner's we, addr, len and wdata at the clock edge, and go to RD or WR.
REQ-021 SHALL treat a len of 0 or greater than NB as NB.
REQ-022 SHALL, for a read of N bytes, drive mem_a = addr+k in cycle k+1 after acceptance (k = 0..N-1), capture mem_din into rdata byte k at the end of cycle k+2, enter RD_TAIL after the last address, and pulse done in cycle N+2.
REQ-023 SHALL, for a write of N bytes, drive mem_wr=1, mem_a=addr+k and mem_dout=wdata byte k in cycle k+1, and pulse done in cycle N+1.
REQ-024 SHALL zero-fill rdata bytes at and above N, and SHALL hold rdata until the next read completes.
REQ-025 SHALL wrap address increments modulo 2^32.
REQ-026 SHALL NOT align addresses: unaligned accesses are legal and byte-serial.
REQ-027 SHALL, in fixed-priority mode (ARB_RR=0), grant the lowest-indexed valid port.
REQ-028 SHALL, in round-robin mode (ARB_RR=1), search from (last granted+1) mod NPORT.
REQ-029 SHALL allow back-to-back transfers: a new request may be accepted in the cycle done pulses, so the FSM returns to IDLE in that cycle.
REQ-030 SHALL drive mem_wr=0 and mem_dout=0 when not in WR, and SHALL drive mem_a=0 in IDLE.
REQ-031 SHALL, when rdy_in is low, hold FSM, counters, latched request, rdata and done unchanged, force mem_wr=0, and hold mem_a; the pending write byte is issued once rdy_in returns high, never twice.
REQ-032 SHALL abort a read if the granted port drops req_valid during RD or RD_TAIL: next state IDLE, no done, rdata unchanged.
REQ-033 SHALL NOT abort writes: req_valid is ignored once a write is granted.
REQ-034 SHALL make busy = (state != IDLE).

Reset
REQ-035 SHALL, on rst_in high at a clock edge, set state=IDLE, done=0, rdata=0, busy=0, mem_wr=0, mem_a=0, mem_dout=0, round-robin pointer=NPORT-1 (so port 0 is searched first).
REQ-036 SHALL let rst_in override rdy_in.
REQ-037 SHALL abandon a transfer interrupted by reset silently, with no done pulse.

Structure
REQ-038 SHALL place the state encoding, size/length helper constants and the I/O base address 0x30000 in the shared defines package.
REQ-039 SHALL implement the grant logic as one sub-module, mem_arb (parametrised NPORT and ARB_RR, combinational grant plus registered pointer); everything else in mem_ctrl.

Verification
REQ-040 Bench SHALL cover: port0 read len=4 at 0x100, memory bytes 11 22 33 44 -> mem_a 0x100..0x103 in cycles 1..4, done[0] in cycle 6, rdata=0x44332211.
REQ-041 Bench SHALL cover: port1 write len=2, addr 0x30000, wdata 0x0000BEEF -> mem_wr high in cycles 1..2 with bytes EF then BE, done[1] in cycle 3.
REQ-042 Bench SHALL cover: both ports valid continuously, ARB_RR=1, len=1 reads -> grants alternate 0,1,0,1; with ARB_RR=0 -> port0 only.
REQ-043 Bench SHALL cover: rdy_in low for 3 cycles during byte 1 of a 4-byte write -> each byte written exactly once, done delayed by exactly 3 cycles.
REQ-044 Bench SHALL cover: port0 drops req_valid in cycle 2 of a 4-byte read -> no done[0], FSM in IDLE next cycle, rdata unchanged.
REQ-045 Bench SHALL cover: read len=2 at 0xFFFFFFFF -> addresses 0xFFFFFFFF then 0x00000000; rdata upper bytes zero.
